// File: rtl/mult_product_accumulator_if.sv
// Product stream in, group-sum result stream out, between the multiplier
// and the accumulator (slave) and its upstream/downstream users (master).
interface mult_product_accumulator_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
);
  logic                    clr;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_prod;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_sum;
  logic [CNT_W-1:0]        out_count;
  logic                    out_sat;

  modport master (
    output clr, in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );
  modport slave (
    input  clr, in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/mult_product_accumulator.sv
// Sums in_last-delimited groups of signed products into a saturating wide
// accumulator and emits each clipped group sum with its term count.
module mult_product_accumulator #(
  parameter int IN_W  = 64,
  parameter int ACC_W = 80,
  parameter int OUT_W = 64,
  parameter int CNT_W = 16
) (
  input logic                      clk,
  input logic                      reset,
  mult_product_accumulator_if.slave io
);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;

  logic signed [ACC_W-1:0] acc, base_acc, acc_nxt;
  logic [CNT_W-1:0]        cnt, base_cnt, cnt_nxt;
  logic                    acc_sat, base_sat, sat_nxt;
  logic signed [ACC_W:0]   wide;
  logic                    ovf, cnt_hit, clip, beat;
  logic signed [OUT_W-1:0] sum_nxt;

  logic                    out_valid_q, out_sat_q;
  logic signed [OUT_W-1:0] out_sum_q;
  logic [CNT_W-1:0]        out_count_q;

  assign io.in_ready  = ~out_valid_q | io.out_ready;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = out_sum_q;
  assign io.out_count = out_count_q;
  assign io.out_sat   = out_sat_q;
  assign beat         = io.in_valid & io.in_ready;

  // clr folds into the base so a beat in the clr cycle opens a fresh group
  always_comb begin
    base_acc = io.clr ? '0 : acc;
    base_cnt = io.clr ? '0 : cnt;
    base_sat = io.clr ? 1'b0 : acc_sat;
    wide     = {base_acc[ACC_W-1], base_acc}
             + {{(ACC_W+1-IN_W){io.in_prod[IN_W-1]}}, io.in_prod};
    ovf      = wide[ACC_W] != wide[ACC_W-1];
    acc_nxt  = ovf ? (wide[ACC_W] ? ACC_MIN : ACC_MAX) : wide[ACC_W-1:0];
    cnt_hit  = base_cnt >= CNT_MAX - CNT_W'(1);
    cnt_nxt  = (base_cnt == CNT_MAX) ? CNT_MAX : base_cnt + CNT_W'(1);
    sat_nxt  = base_sat | ovf | cnt_hit;
    clip     = 1'b0;
    sum_nxt  = acc_nxt[OUT_W-1:0];
    if (acc_nxt > OUT_MAX) begin
      sum_nxt = OUT_MAX[OUT_W-1:0];
      clip    = 1'b1;
    end else if (acc_nxt < OUT_MIN) begin
      sum_nxt = OUT_MIN[OUT_W-1:0];
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      acc_sat <= 1'b0;
    end else if (beat && !io.in_last) begin
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      acc_sat <= sat_nxt;
    end else if (beat || io.clr) begin
      acc     <= '0;
      cnt     <= '0;
      acc_sat <= 1'b0;
    end
  end

  // A last beat on the release edge reloads, giving back-to-back results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (beat && io.in_last) begin
      out_valid_q <= 1'b1;
      out_sum_q   <= sum_nxt;
      out_count_q <= cnt_nxt;
      out_sat_q   <= sat_nxt | clip;
    end else if (io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed vectors with hand-computed group sums for mult_product_accumulator.
module tb_mult_product_accumulator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  mult_product_accumulator_if #(.IN_W(64), .OUT_W(64), .CNT_W(16)) bus ();

  mult_product_accumulator #(.IN_W(64), .ACC_W(80), .OUT_W(64), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [63:0] p, input logic last);
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_last  = last;
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [63:0] sum,
                         input logic [63:0] cnt, input logic sat);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
    chk({tag, ".sum"},   bus.out_sum, sum);
    chk({tag, ".count"}, 64'(bus.out_count), cnt);
    chk({tag, ".sat"},   64'(bus.out_sat), 64'(sat));
  endtask

  initial begin
    bus.clr = 1'b0; bus.in_valid = 1'b0; bus.in_prod = '0;
    bus.in_last = 1'b0; bus.out_ready = 1'b1;
    #12;
    chk("rst.valid", 64'(bus.out_valid), 64'd0);
    chk("rst.sum",   bus.out_sum, 64'd0);
    chk("rst.count", 64'(bus.out_count), 64'd0);
    chk("rst.sat",   64'(bus.out_sat), 64'd0);
    chk("rst.in_ready", 64'(bus.in_ready), 64'd1);
    reset = 1'b1;
    tick();

    // three-term group
    beat(64'sd3360, 1'b0);
    beat(-64'sd300, 1'b0);
    chk("g3.pre", 64'(bus.out_valid), 64'd0);
    beat(64'sd289, 1'b1);
    chk_out("g3", 64'd3349, 64'd3, 1'b0);

    // single-term group taken on the release edge
    beat(64'sd35427456, 1'b1);
    chk_out("g1", 64'd35427456, 64'd1, 1'b0);
    tick();
    chk("g1.drop", 64'(bus.out_valid), 64'd0);

    // back-to-back groups, no bubble
    bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_prod = 64'sd1512;
    tick();
    chk_out("b2b0", 64'd1512, 64'd1, 1'b0);
    chk("b2b0.in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_prod = 64'sd57420;
    tick();
    chk_out("b2b1", 64'd57420, 64'd1, 1'b0);
    chk("b2b1.in_ready", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tick();
    chk("b2b.drop", 64'(bus.out_valid), 64'd0);

    // backpressure: held beat waits until out_ready rises
    bus.out_ready = 1'b0;
    beat(64'sd10, 1'b1);
    chk_out("hold0", 64'd10, 64'd1, 1'b0);
    chk("hold.in_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1; bus.in_last = 1'b1; bus.in_prod = 64'sd20;
    tick();
    tick();
    chk_out("hold1", 64'd10, 64'd1, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    chk("rel.in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    chk_out("rel", 64'd20, 64'd1, 1'b0);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    tick();
    chk("rel.drop", 64'(bus.out_valid), 64'd0);

    // positive clip, then sticky flag clears with the group
    beat(64'sh4000_0000_0000_0000, 1'b0);
    beat(64'sh4000_0000_0000_0000, 1'b1);
    chk_out("pclip", 64'h7FFF_FFFF_FFFF_FFFF, 64'd2, 1'b1);
    beat(-64'sd5, 1'b1);
    chk_out("after", 64'hFFFF_FFFF_FFFF_FFFB, 64'd1, 1'b0);

    // negative clip
    beat(64'sh8000_0000_0000_0000, 1'b0);
    beat(-64'sd1, 1'b1);
    chk_out("nclip", 64'h8000_0000_0000_0000, 64'd2, 1'b1);

    // clr with a last beat starts a fresh one-term group
    beat(64'sd100, 1'b0);
    beat(64'sd200, 1'b0);
    bus.clr = 1'b1;
    beat(64'sd7, 1'b1);
    bus.clr = 1'b0;
    chk_out("clr", 64'd7, 64'd1, 1'b0);

    // reset mid-group drops partial sum and pending output
    beat(64'sd9, 1'b0);
    reset = 1'b0;
    #1;
    chk("mrst.valid", 64'(bus.out_valid), 64'd0);
    chk("mrst.sum",   bus.out_sum, 64'd0);
    tick();
    reset = 1'b1;
    tick();
    beat(64'sd4, 1'b1);
    chk_out("postrst", 64'd4, 64'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mult_product_accumulator.md
Name: mult_product_accumulator

Overview:
- Downstream stage of the 32x32 signed simple multiplier. Consumes its registered 64-bit signed products one per cycle.
- Sums each group of products, delimited by in_last, into a wide internal accumulator. This gives a dot-product / MAC result.
- Presents each finished sum, saturated to OUT_W, with a term count on a valid/ready output port.
- Lets the multiplier stream continuously while the consumer applies backpressure.

Parameters:
- IN_W, 64, signed product width (matches multiplier result).
- ACC_W, 80, internal accumulator width (IN_W + CNT_W; no overflow for <= 2^CNT_W-1 terms).
- OUT_W, 64, signed output sum width (saturated from ACC_W).
- CNT_W, 16, term counter width.

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous discard of the partial group in progress.
- in_valid, input, 1, product beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- in_prod, input, IN_W, signed product from the multiplier.
- in_last, input, 1, beat closes the current group.
- out_valid, output, 1, out_sum/out_count/out_sat valid.
- out_ready, input, 1, consumer takes the result.
- out_sum, output, OUT_W, signed group sum, saturated.
- out_count, output, CNT_W, number of terms in the group.
- out_sat, output, 1, out_sum was clipped, or the accumulator saturated.

Behaviour:
- Reset (reset=0, asynchronous): acc=0, cnt=0, acc_sat=0, out_valid=0, out_sum=0, out_count=0, out_sat=0.
- Beat accepted when in_valid & in_ready. in_ready = ~out_valid | out_ready, combinational.
- Non-last beat, next cycle: acc <= acc + sext(in_prod); cnt <= cnt+1.
- Last beat, next cycle:
  - out_sum <= sat_OUT_W(acc + sext(in_prod)); out_count <= cnt+1; out_valid <= 1.
  - out_sat <= acc_sat | clip.
  - acc, cnt and acc_sat are then cleared.
- Latency: last beat at edge N gives out_valid high after edge N, i.e. 1 cycle.
- Output hold: out_sum/out_count/out_sat stay stable while out_valid & ~out_ready.
- Output release: out_valid falls after the out_valid & out_ready edge, unless a new last beat is accepted on that same edge. In that case out_valid stays 1 and new data loads, giving back-to-back results with no bubble.
- A single-beat group (in_last on the first beat) gives out_count=1 and out_sum=in_prod, clipped if needed.
- Accumulator arithmetic: signed, saturating at ACC_W limits.
  - Any clamp sets sticky acc_sat.
  - acc_sat clears with the group.
- Term counter: cnt saturates at 2^CNT_W-1. Reaching that limit also sets acc_sat.
- Output saturation: sat_OUT_W clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- States (implicit):
  - EMPTY: cnt=0.
  - ACCUM: cnt>0.
  - HOLD: out_valid & ~out_ready, so in_ready=0.
  - Group accumulation continues in ACCUM regardless of the output state, except that input stalls in HOLD.
- clr=1:
  - acc, cnt and acc_sat are cleared and the partial group is discarded.
  - A beat accepted in the same cycle is not lost. It starts a fresh group: acc <= sext(in_prod), cnt <= 1. If it is also last, a one-term result is produced.
  - clr does not affect a pending out_valid result.
- in_valid=0 cycles within a group are allowed; state holds.
- Reset asserted mid-group or mid-HOLD: all state and outputs return to reset values immediately. The pending result is lost.

Test Plan:
- Reset, then beats 3360, -300, 289 (last) with out_ready=1 -> out_valid one cycle after the last beat; out_sum=3349, out_count=3, out_sat=0.
- Single beat 35427456 with in_last -> out_sum=35427456, out_count=1.
- Groups {1512, last} and {57420, last} on consecutive cycles with out_ready=1 -> out_valid stays high two cycles; out_sum=1512 then 57420; in_ready never drops.
- out_ready=0 while a result is pending -> in_ready=0. Beats held on the inputs are not consumed and out_sum is stable. Raising out_ready releases the result and accepts the held beat on the same edge.
- Beats 2^62, 2^62 (last) -> out_sum=2^63-1, out_sat=1, out_count=2. The next group {-5, last} -> out_sum=-5, out_sat=0.
- Beats 100, 200, then clr with beat 7 last -> out_sum=7, out_count=1. Then beat 9 (not last), assert reset for 1 cycle, then {4, last} -> out_sum=4, out_count=1.
